// File: rtl/sw_traceback_reader.sv
// Smith-Waterman traceback reader.
// Walks the direction words stored by the PE array backwards from the max-score
// cell and emits one alignment operation (M/I/D) per consumed cell.
// Optional build macro SW_TB_RLE_EN: merge consecutive identical operations into
// run-length transfers and expose the op_len port.
module sw_traceback_reader #(
   parameter int unsigned REF_LEN_WIDTH   = 10,
   parameter int unsigned QUERY_LEN_WIDTH = 10
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic [REF_LEN_WIDTH-1:0]                 start_ref_pos,
   input  logic [QUERY_LEN_WIDTH-1:0]               start_query_pos,
   output logic                                     busy,
   output logic                                     done,
   output logic [REF_LEN_WIDTH-1:0]                 end_ref_pos,
   output logic [QUERY_LEN_WIDTH-1:0]               end_query_pos,
   output logic                                     rd_en,
   output logic [QUERY_LEN_WIDTH+REF_LEN_WIDTH-1:0] rd_addr,
   input  logic [3:0]                               rd_data,
   output logic                                     op_valid,
   input  logic                                     op_ready,
   output logic [1:0]                               op_code
`ifdef SW_TB_RLE_EN
   ,
   output logic [REF_LEN_WIDTH-1:0]                 op_len
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_EVAL,
      S_EMIT,
      S_FIN
   } state_t;

   typedef enum logic [1:0] {
      MAT_H,
      MAT_E,
      MAT_F
   } mat_t;

   localparam logic [1:0] OP_M = 2'd0;
   localparam logic [1:0] OP_I = 2'd1;
   localparam logic [1:0] OP_D = 2'd2;

   localparam logic [1:0] DIR_ZERO  = 2'd0;
   localparam logic [1:0] DIR_VER   = 2'd1;
   localparam logic [1:0] DIR_HOR   = 2'd2;
   localparam logic [1:0] DIR_MATCH = 2'd3;

   state_t                     state;
   mat_t                       mat;
   logic [QUERY_LEN_WIDTH-1:0] q;
   logic [REF_LEN_WIDTH-1:0]   r;
   logic [QUERY_LEN_WIDTH-1:0] last_q;
   logic [REF_LEN_WIDTH-1:0]   last_r;
   logic [3:0]                 dir_reg;
   logic                       fin_pend;

`ifdef SW_TB_RLE_EN
   localparam logic [REF_LEN_WIDTH-1:0] RUN_MAX = '1;
   logic [1:0]               run_code;
   logic [REF_LEN_WIDTH-1:0] run_len;
`endif

   // Decode of the latched direction word for the current matrix
   logic                       has_op;
   logic                       walk_end;
   logic [1:0]                 cell_op;
   mat_t                       mat_nxt;
   logic [QUERY_LEN_WIDTH-1:0] q_nxt;
   logic [REF_LEN_WIDTH-1:0]   r_nxt;

   // Decide the op for this cell, the next matrix and the next coordinates
   always_comb begin
      has_op   = 1'b0;
      walk_end = 1'b0;
      cell_op  = OP_M;
      mat_nxt  = mat;
      q_nxt    = q;
      r_nxt    = r;
      unique case (mat)
         MAT_H: begin
            unique case (dir_reg[1:0])
               DIR_ZERO:  walk_end = 1'b1;
               DIR_VER:   mat_nxt = MAT_F;
               DIR_HOR:   mat_nxt = MAT_E;
               DIR_MATCH: begin
                  has_op  = 1'b1;
                  cell_op = OP_M;
               end
               default: ;
            endcase
         end
         MAT_F: begin
            has_op  = 1'b1;
            cell_op = OP_I;
            mat_nxt = dir_reg[2] ? MAT_H : MAT_F;
         end
         MAT_E: begin
            has_op  = 1'b1;
            cell_op = OP_D;
            mat_nxt = dir_reg[3] ? MAT_H : MAT_E;
         end
         default: ;
      endcase
      // Step back; an index already at 0 terminates the walk instead of wrapping
      if (has_op) begin
         unique case (cell_op)
            OP_M: begin
               if (q == '0 || r == '0) walk_end = 1'b1;
               else begin
                  q_nxt = q - 1'b1;
                  r_nxt = r - 1'b1;
               end
            end
            OP_I: begin
               if (q == '0) walk_end = 1'b1;
               else q_nxt = q - 1'b1;
            end
            OP_D: begin
               if (r == '0) walk_end = 1'b1;
               else r_nxt = r - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Traceback FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         mat           <= MAT_H;
         q             <= '0;
         r             <= '0;
         last_q        <= '0;
         last_r        <= '0;
         dir_reg       <= '0;
         fin_pend      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         end_ref_pos   <= '0;
         end_query_pos <= '0;
         rd_en         <= 1'b0;
         rd_addr       <= '0;
         op_valid      <= 1'b0;
         op_code       <= '0;
`ifdef SW_TB_RLE_EN
         op_len        <= '0;
         run_code      <= '0;
         run_len       <= '0;
`endif
      end else begin
         done  <= 1'b0;
         rd_en <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  q       <= start_query_pos;
                  r       <= start_ref_pos;
                  last_q  <= start_query_pos;
                  last_r  <= start_ref_pos;
                  mat     <= MAT_H;
                  busy    <= 1'b1;
                  rd_en   <= 1'b1;
                  rd_addr <= {start_query_pos, start_ref_pos};
`ifdef SW_TB_RLE_EN
                  run_len <= '0;
`endif
                  state   <= S_RD;
               end
            end
            S_RD: state <= S_WT;
            S_WT: begin
               dir_reg <= rd_data;
               state   <= S_EVAL;
            end
            S_EVAL: begin
               mat <= mat_nxt;
               if (has_op) begin
                  q      <= q_nxt;
                  r      <= r_nxt;
                  last_q <= q;
                  last_r <= r;
               end
`ifdef SW_TB_RLE_EN
               if (has_op) begin
                  if (run_len != '0 && (run_code != cell_op || run_len == RUN_MAX)) begin
                     // Close the current run; this cell opens the next one
                     op_valid <= 1'b1;
                     op_code  <= run_code;
                     op_len   <= run_len;
                     run_code <= cell_op;
                     run_len  <= REF_LEN_WIDTH'(1);
                     fin_pend <= walk_end;
                     state    <= S_EMIT;
                  end else if (walk_end) begin
                     op_valid <= 1'b1;
                     op_code  <= cell_op;
                     op_len   <= run_len + 1'b1;
                     run_len  <= '0;
                     fin_pend <= 1'b1;
                     state    <= S_EMIT;
                  end else begin
                     run_code <= cell_op;
                     run_len  <= run_len + 1'b1;
                     rd_en    <= 1'b1;
                     rd_addr  <= {q_nxt, r_nxt};
                     state    <= S_RD;
                  end
               end else if (walk_end) begin
                  if (run_len != '0) begin
                     op_valid <= 1'b1;
                     op_code  <= run_code;
                     op_len   <= run_len;
                     run_len  <= '0;
                     fin_pend <= 1'b1;
                     state    <= S_EMIT;
                  end else begin
                     state <= S_FIN;
                  end
               end
`else
               if (has_op) begin
                  op_valid <= 1'b1;
                  op_code  <= cell_op;
                  fin_pend <= walk_end;
                  state    <= S_EMIT;
               end else if (walk_end) begin
                  state <= S_FIN;
               end
`endif
            end
            S_EMIT: begin
               if (op_ready) begin
`ifdef SW_TB_RLE_EN
                  if (fin_pend && run_len != '0) begin
                     // Flush the run left open by the terminating cell
                     op_code <= run_code;
                     op_len  <= run_len;
                     run_len <= '0;
                  end else begin
                     op_valid <= 1'b0;
                     if (fin_pend) state <= S_FIN;
                     else begin
                        rd_en   <= 1'b1;
                        rd_addr <= {q, r};
                        state   <= S_RD;
                     end
                  end
`else
                  op_valid <= 1'b0;
                  if (fin_pend) state <= S_FIN;
                  else begin
                     rd_en   <= 1'b1;
                     rd_addr <= {q, r};
                     state   <= S_RD;
                  end
`endif
               end
            end
            S_FIN: begin
               done          <= 1'b1;
               busy          <= 1'b0;
               end_query_pos <= last_q;
               end_ref_pos   <= last_r;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sw_traceback_reader.md
Name: sw_traceback_reader

Overview:
- Consumes the direction words that the Smith-Waterman PE array writes into the traceback memory (dir[3:0] at {query row, ref pos}).
- Starting from the max-score cell reported by the array, walks the H/E/F matrices backwards and emits one alignment operation per consumed cell: M (match/mismatch), I (query-only), D (ref-only).
- Sits between the traceback RAM read port and the CIGAR packer / host output stream.

Parameters:
- REF_LEN_WIDTH, 10, width of a reference position.
- QUERY_LEN_WIDTH, 10, width of a query position.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begin traceback; ignored unless idle
- start_ref_pos  in  REF_LEN_WIDTH  ref index of the max cell (0-based)
- start_query_pos  in  QUERY_LEN_WIDTH  query index of the max cell (0-based)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; traceback finished
- end_ref_pos  out  REF_LEN_WIDTH  ref index of the last consumed cell
- end_query_pos  out  QUERY_LEN_WIDTH  query index of the last consumed cell
- rd_en  out  1  traceback RAM read strobe
- rd_addr  out  QUERY_LEN_WIDTH+REF_LEN_WIDTH  {query, ref}
- rd_data  in  4  direction word, valid the cycle after rd_en (synchronous RAM)
- op_valid  out  1  operation available
- op_ready  in  1  downstream accept
- op_code  out  2  0=M, 1=I, 2=D
- op_len  out  REF_LEN_WIDTH  run length (present only with SW_TB_RLE_EN)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; mat=H. Reset mid-walk aborts the walk: no done pulse, busy drops the next cycle.
- Direction word: bit3=1 means E opened from H (else extended); bit2=1 means F opened from H; [1:0]: 0=ZERO, 1=VER(F), 2=HOR(E), 3=MATCH.
- FSM states: IDLE, RD, WT, EVAL, EMIT, FIN.
  - IDLE: on start, latch q=start_query_pos, r=start_ref_pos, mat=H, go to RD.
  - RD: rd_en=1, rd_addr={q,r}, go to WT.
  - WT: latch rd_data into dir_reg, go to EVAL.
  - EVAL, mat=H:
    - ZERO: go to FIN, no op.
    - VER: mat=F, stay in EVAL one cycle, no read.
    - HOR: mat=E, stay in EVAL one cycle, no read.
    - MATCH: op=M, go to EMIT.
  - EVAL, mat=F: op=I; next mat = dir_reg[2] ? H : F.
  - EVAL, mat=E: op=D; next mat = dir_reg[3] ? H : E.
  - EMIT: op_valid=1; op_code and op_len held stable until op_ready. On handshake:
    - M: q-1, r-1.
    - I: q-1.
    - D: r-1.
    - If a decremented index was already 0, go to FIN; otherwise go to RD.
  - FIN: done=1 for one cycle, end_* = coordinates of the last consumed cell, go to IDLE.
- end_* on a zero-length walk: equal to the start coordinates. end_* holds until the next start.
- Latency: start in cycle 0 → rd_en in cycle 1 → op_valid in cycle 4 (cycle 5 when the start cell is VER or HOR). With op_ready held high, each further M/I/D costs 4 cycles.
- start while busy: ignored. op_ready with op_valid low: no effect.
- Index arithmetic is unsigned; the walk never wraps below 0.

Optional Feature:
- Macro: SW_TB_RLE_EN.
- Defined:
  - Consecutive identical op codes merge into one transfer carrying op_len = run count.
  - A run is emitted when the code changes or the walk terminates; the final run is flushed before done.
  - A run saturates at 2^REF_LEN_WIDTH-1, is then emitted, and a new run starts.
  - op_len port exists.
- Undefined: one transfer per cell; op_len port absent.

Test Plan:
- RAM (2,2)=MATCH, (1,1)=MATCH, (0,0)=MATCH; start (q=2, r=2), op_ready=1 → ops M,M,M; done; end=(0,0); first op_valid in cycle 4.
- (3,5)=MATCH, (2,4)=HOR with bit3=0, (2,3)=E word bit3=0, (2,2)=E word bit3=1, (2,1)=ZERO → ops M,D,D,D; done; end=(2,2); no RAM read of (2,4) after the transition into E.
- (4,4)=VER, F words at (4,4) bit2=0 and (3,4) bit2=1, (2,4)=MATCH, (1,3)=ZERO → ops I,I,M; end=(2,4).
- Start cell ZERO at (7,9) → no op_valid; done in cycle 5; end=(7,9).
- op_ready low for 6 cycles during the first EMIT → op_code stable and no rd_en while stalled; a start pulse while busy is ignored; rst mid-walk → outputs 0, no done pulse.
- SW_TB_RLE_EN with the HOR scenario → transfers (M,1), (D,3), then done.
